skew_feeder: RTL and testbench
==============================

// Module: skew_feeder
// PURPOSE
//  Parametrised successor to the fixed 4x16 data decoder. Takes one BRAM row per beat
//   (N lanes x W bits) over a valid/ready handshake and skews lane i by i cycles.
//   The systolic array therefore receives a diagonal wavefront.
//  Tracks tile boundaries, drains the skew pipeline, and pulses compute_start/tile_done
//   to the array controller. Sits between the operand BRAM read port and the PE array edge.
// PARAMETERS
//  REG_WIDTH    16   bits per lane element (W)
//  MATRIX_SIZE  4    lanes / array edge length (N), >=2
//  MAX_BEATS    64   max beats per tile; beat counter width $clog2(MAX_BEATS)
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  enable         in   1      global run; 0 freezes the block
//  in_valid       in   1      in_data/in_last valid
//  in_ready       out  1      beat accepted when in_valid&&in_ready
//  in_data        in   N*W    lane i = in_data[i*W +: W]
//  in_last        in   1      final beat of tile
//  out_data       out  N*W    skewed lane data, lane i = out_data[i*W +: W]
//  out_valid      out  N      per-lane valid
//  compute_start  out  1      1-cycle pulse: first beat of tile on lane 0
//  tile_done      out  1      1-cycle pulse: tile fully drained from lane N-1
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, skew registers and valid bits cleared, beat_cnt=0.
//   Reset wins over all other inputs in the same cycle; reset mid-tile discards in-flight data.
//  Skew: lane i is a chain of i+1 registers holding {valid,data}.
//   A beat accepted at edge t appears on lane i after edge t+i (lane 0 = 1 registered stage).
//  Bubbles: a cycle with enable=1 and no accept shifts {0,0} into every lane head.
//   out_data is 0 wherever out_valid is 0.
//  enable=0: all registers hold; in_ready=0; out_valid forced 0; compute_start/tile_done=0.
//   Pulses pending on a frozen cycle fire on the next enabled cycle.
//  FSM:
//   IDLE   -> STREAM on first accept
//   STREAM -> DRAIN on accept with in_last, or on forced last (beat_cnt==MAX_BEATS-1)
//   DRAIN  counts N-1 enabled cycles with in_ready=0 -> IDLE, asserting tile_done
//          in the cycle lane N-1 presents the last beat
//  in_ready = enable && (state != DRAIN) && !reset.
//  Single-beat tile: IDLE -> DRAIN directly; compute_start and the last beat coincide on lane 0.
//  compute_start is asserted in the cycle out_valid[0] shows beat 0 of a tile.
//  beat_cnt increments per accept, clears on the accept that ends the tile.
//   Forced last at MAX_BEATS-1 ignores in_last.
//  Back-to-back tiles are impossible: no accept during DRAIN, minimum tile gap N-1 cycles.
// CONFIGURATION
//  SKEW_FEEDER_PERF_CNT_EN defined:
//   adds out port stall_cnt [31:0], which counts cycles with in_valid&&!in_ready&&enable;
//   cleared by reset, saturates at 2^32-1.
//  SKEW_FEEDER_PERF_CNT_EN undefined: port and counter absent, behaviour otherwise identical.
// STRUCTURE
//  Shared package skew_feeder_pkg:
//   state_e {IDLE,STREAM,DRAIN};
//   lane_t struct {logic valid; logic [W-1:0] data} (W via package parameter default 16);
//   function clog2-safe width helper.
//  Sub-module skew_lane #(DEPTH,W):
//   per-lane shift chain with hold enable, instantiated N times via generate (DEPTH=i+1).
//  Top holds FSM, beat counter, drain counter, pulse generation.
// TESTING (N=4, W=16, MAX_BEATS=64)
//  1 Reset held 20 cycles with in_valid=1 -> all outputs 0, in_ready=0; first post-reset edge
//    leaves state IDLE.
//  2 One beat 64'h0004_0003_0002_0001 with in_last -> lane0=0001 at t+1, lane3=0004 at t+4;
//    compute_start at t+1; tile_done at t+4; in_ready=0 for 3 cycles.
//  3 Four beats 0x..00k1..k4 continuous, last on 4th -> diagonal pattern on out_valid
//    0001,0011,0111,1111,1110,1100,1000; one compute_start, one tile_done.
//  4 enable dropped 2 cycles mid-STREAM -> out_valid=0 and registers held; data resumes
//    unchanged; total latency +2.
//  5 70 beats, in_last never set -> forced DRAIN after beat 64; in_ready low 3 cycles;
//    beats 65-70 form a new tile with a new compute_start.
//  6 reset asserted during DRAIN -> next cycle all outputs 0, no tile_done; with
//    SKEW_FEEDER_PERF_CNT_EN, stall_cnt counts exactly the DRAIN stall cycles then clears.

Source files
------------

// File: rtl/skew_feeder_pkg.sv
// Shared types and helpers for the skew feeder: FSM states, lane element, counter width helper.
package skew_feeder_pkg;

  localparam int unsigned LANE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] data;
  } lane_t;

  // Width that always holds values 0..n-1 and never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One skew lane: DEPTH-stage {valid,data} shift chain that advances only while i_en is high.
module skew_lane #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) r_data[k] <= '0;
    end else if (i_en) begin
      // Bubbles carry zero data so the output needs no extra masking.
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= r_data[k-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// Skews N lanes of a BRAM row into a diagonal wavefront and frames tiles for the array.
// Optional stall counter port stall_cnt when SKEW_FEEDER_PERF_CNT_EN is defined.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int unsigned REG_WIDTH   = 16,
  parameter int unsigned MATRIX_SIZE = 4,
  parameter int unsigned MAX_BEATS   = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [MATRIX_SIZE*REG_WIDTH-1:0] in_data,
  input  logic                             in_last,
  output logic [MATRIX_SIZE*REG_WIDTH-1:0] out_data,
  output logic [MATRIX_SIZE-1:0]           out_valid,
  output logic                             compute_start,
  output logic                             tile_done,
  output logic                             busy
`ifdef SKEW_FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]                      stall_cnt
`endif
);

  localparam int unsigned BEAT_W  = cnt_width(MAX_BEATS);
  localparam int unsigned DRAIN_W = cnt_width(MATRIX_SIZE - 1);

  state_e                           r_state, w_state_nxt;
  logic [BEAT_W-1:0]                r_beat_cnt;
  logic [DRAIN_W-1:0]               r_drain_cnt;
  logic                             r_first;
  logic [MATRIX_SIZE-1:0]           r_last_sr;
  logic                             w_accept;
  logic                             w_last;
  logic [MATRIX_SIZE-1:0]           w_lane_valid;
  logic [MATRIX_SIZE*REG_WIDTH-1:0] w_lane_data;

  assign in_ready = enable && (r_state != DRAIN) && !reset;
  assign w_accept = in_valid && in_ready;
  assign w_last   = w_accept && (in_last || (r_beat_cnt == BEAT_W'(MAX_BEATS - 1)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_last ? DRAIN : STREAM;
      STREAM:  if (w_last) w_state_nxt = DRAIN;
      DRAIN:   if (enable && (r_drain_cnt == DRAIN_W'(MATRIX_SIZE - 2))) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_first     <= 1'b0;
      r_last_sr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_beat_cnt <= w_last ? '0 : r_beat_cnt + BEAT_W'(1);
      if (enable) begin
        r_drain_cnt <= (r_state == DRAIN && w_state_nxt == DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
        // Tile markers ride alongside lane 0 / lane N-1 so the pulses line up with the data.
        r_first   <= w_accept && (r_beat_cnt == '0);
        r_last_sr <= {r_last_sr[MATRIX_SIZE-2:0], w_last};
      end
    end
  end

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    skew_lane #(
      .DEPTH(i + 1),
      .W    (REG_WIDTH)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_en   (enable),
      .i_valid(w_accept),
      .i_data (in_data[i*REG_WIDTH +: REG_WIDTH]),
      .o_valid(w_lane_valid[i]),
      .o_data (w_lane_data[i*REG_WIDTH +: REG_WIDTH])
    );
  end

  assign out_valid     = enable ? w_lane_valid : '0;
  assign out_data      = enable ? w_lane_data : '0;
  assign compute_start = enable && r_first;
  assign tile_done     = enable && r_last_sr[MATRIX_SIZE-1];
  assign busy          = (r_state != IDLE);

`ifdef SKEW_FEEDER_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !in_ready && enable && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_skew_feeder.sv
// Randomised bench for skew_feeder against a beat-history reference model.
module tb_skew_feeder;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 64;

  logic           clk = 1'b0;
  logic           reset, enable, in_valid, in_last;
  logic [N*W-1:0] in_data;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic           compute_start, tile_done, busy;
`ifdef SKEW_FEEDER_PERF_CNT_EN
  logic [31:0]    stall_cnt;
`endif

  always #5 clk = ~clk;

  skew_feeder #(
    .REG_WIDTH  (W),
    .MATRIX_SIZE(N),
    .MAX_BEATS  (MB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .compute_start(compute_start),
    .tile_done    (tile_done),
    .busy         (busy)
`ifdef SKEW_FEEDER_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // One entry per enabled clock edge, newest first: what each lane head received.
  typedef struct {
    bit             v;
    bit             first;
    bit             last;
    logic [N*W-1:0] d;
  } ent_t;

  ent_t        hist[$];
  int          tile_cnt   = 0;
  int          since_last = N;
  longint      stalls_m   = 0;
  int          checks     = 0;
  int          failures   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit vld,
                      input logic [N*W-1:0] d, input bit lst, output bit acc);
    bit             exp_ready, exp_busy, cs, td;
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    ent_t           e;
    reset = rst; enable = en; in_valid = vld; in_data = d; in_last = lst;
    @(negedge clk);
    exp_ready = en && !rst && !(since_last <= N-2);
    exp_busy  = (tile_cnt > 0) || (since_last <= N-2);
    ev = '0; ed = '0;
    if (en)
      for (int i = 0; i < N; i++)
        if (i < hist.size() && hist[i].v) begin
          ev[i] = 1'b1;
          ed[i*W +: W] = hist[i].d[i*W +: W];
        end
    cs = en && hist.size() > 0 && hist[0].first;
    td = en && hist.size() > N-1 && hist[N-1].last;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("busy", 64'(busy), 64'(exp_busy));
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data", 64'(out_data), 64'(ed));
    check("compute_start", 64'(compute_start), 64'(cs));
    check("tile_done", 64'(tile_done), 64'(td));
`ifdef SKEW_FEEDER_PERF_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stalls_m));
`endif
    acc = vld && exp_ready;
    @(posedge clk);
    if (rst) begin
      hist.delete();
      tile_cnt = 0; since_last = N; stalls_m = 0;
    end else if (en) begin
      if (vld && !exp_ready && stalls_m < 64'hFFFF_FFFF) stalls_m++;
      if (since_last < N) since_last++;
      e.v     = acc;
      e.d     = acc ? d : '0;
      e.first = acc && (tile_cnt == 0);
      e.last  = acc && (lst || tile_cnt == MB-1);
      if (acc) begin
        if (e.last) begin tile_cnt = 0; since_last = 0; end
        else tile_cnt++;
      end
      hist.push_front(e);
      if (hist.size() > N) void'(hist.pop_back());
    end
    #1;
  endtask

  function automatic logic [N*W-1:0] beat_word(input int k);
    logic [N*W-1:0] w;
    for (int i = 0; i < N; i++) w[i*W +: W] = 16'(k * 16 + i + 1);
    return w;
  endfunction

  initial begin
    bit acc;
    int sent;
    reset = 1'b1; enable = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = '0;
    @(posedge clk); #1;

    repeat (20) step(1, 1, 1, {$urandom, $urandom}, 0, acc);

    step(0, 1, 1, 64'h0004_0003_0002_0001, 1, acc);
    repeat (6) step(0, 1, 0, '0, 0, acc);

    for (int k = 1; k <= 4; k++) step(0, 1, 1, beat_word(k), k == 4, acc);
    repeat (8) step(0, 1, 0, '0, 0, acc);

    for (int k = 1; k <= 2; k++) step(0, 1, 1, beat_word(k), 0, acc);
    repeat (2) step(0, 0, 1, beat_word(3), 0, acc);
    for (int k = 3; k <= 4; k++) step(0, 1, 1, beat_word(k), k == 4, acc);
    repeat (8) step(0, 1, 0, '0, 0, acc);

    sent = 0;
    for (int guard = 0; guard < 200 && sent < 70; guard++) begin
      step(0, 1, 1, beat_word(sent), sent == 69, acc);
      if (acc) sent++;
    end
    check("seventy_beats_sent", 64'(sent), 64'd70);
    repeat (8) step(0, 1, 0, '0, 0, acc);

    for (int k = 1; k <= 3; k++) step(0, 1, 1, beat_word(k), k == 3, acc);
    repeat (2) step(0, 1, 1, beat_word(9), 0, acc);
    step(1, 1, 1, beat_word(9), 0, acc);
    repeat (6) step(0, 1, 0, '0, 0, acc);

    for (int c = 0; c < 3000; c++)
      step(($urandom % 200) == 0, ($urandom % 6) != 0, ($urandom % 4) != 0,
           {$urandom, $urandom}, ($urandom % 12) == 0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
